wb_commit_stage: RTL and testbench

Parametrised MEM/WB pipeline register and commit point for the RISC-V core. It latches the memory-stage result and drives the register-file write port. It obeys the global stall/flush protocol and counts retired instructions. It also buffers a per-instruction commit trace in a small FIFO that a debug or testbench consumer drains through a valid/ready handshake.

---
 rtl/wb_commit_stage_pkg.sv | 25 ++
 rtl/wb_trace_fifo.sv | 76 +++++++
 rtl/wb_commit_stage.sv | 116 +++++++++++
 tb/tb_wb_commit_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_stage_pkg.sv
// Shared constants and trace-entry layout for the MEM/WB commit stage.
package wb_commit_stage_pkg;

    localparam int STALL_WB   = 5;
    localparam int STALL_NEXT = 6;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [4:0]  ZeroRegAddr = 5'd0;

    // Entry layout at the default widths; MSB first in the packed FIFO word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
    } trace_entry_t;

    localparam int TRACE_W = $bits(trace_entry_t);

    function automatic int trace_entry_w(input int xlen, input int ilen, input int reg_aw);
        return (2 * xlen) + ilen + reg_aw + 1;
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous trace FIFO: entries offered while full (with no pop) are dropped and counted.
module wb_trace_fifo
    import wb_commit_stage_pkg::*;
#(
    parameter int W      = TRACE_W,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [W-1:0]      i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [W-1:0]      o_data,
    output logic [DROP_W-1:0] o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]      r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DROP_W-1:0] r_drop;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = !w_empty && i_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok = i_push && (!w_full || w_pop);

    // Storage array, no reset needed since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Pointers and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
            r_drop   <= {DROP_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (i_push && w_full && !w_pop && (r_drop != {DROP_W{1'b1}})) begin
                r_drop <= r_drop + DROP_W'(1);
            end
        end
    end

    // Head output, forced to zero while empty
    always_comb begin
        o_data = {W{1'b0}};
        if (!w_empty) begin
            o_data = r_mem[r_rd_ptr[AW-1:0]];
        end else begin
            o_data = {W{1'b0}};
        end
    end

    assign o_valid = !w_empty;
    assign o_drop  = r_drop;

endmodule

// File: rtl/wb_commit_stage.sv
// MEM/WB pipeline register and commit point: drives the register-file write port,
// counts retirements and stages a commit trace into wb_trace_fifo.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ILEN        = 32,
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 64,
    parameter int TRACE_DEPTH = 8,
    parameter int DROP_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              stall_next_i,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [ILEN-1:0]   inst_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              we,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [XLEN-1:0]   trace_pc,
    output logic [ILEN-1:0]   trace_inst,
    output logic [REG_AW-1:0] trace_waddr,
    output logic [XLEN-1:0]   trace_wdata,
    output logic              trace_we,
    output logic [DROP_W-1:0] trace_drop
);

    localparam int TW = trace_entry_w(XLEN, ILEN, REG_AW);

    logic              r_we;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              r_push;
    logic [TW-1:0]     r_entry;

    logic          w_bubble;
    logic          w_hold;
    logic          w_eff_we;
    logic          w_is_inst;
    logic [TW-1:0] w_head;

    assign w_bubble  = flush_i || (stall_i && !stall_next_i);
    assign w_hold    = stall_i && stall_next_i;
    assign w_eff_we  = wreg_i && (wd_i != REG_AW'(ZeroRegAddr));
    assign w_is_inst = (inst_i != {ILEN{1'b0}});

    // Pipeline register, counters and one-cycle trace staging
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_waddr      <= REG_AW'(ZeroRegAddr);
            r_wdata      <= XLEN'(ZeroWord);
            r_retire_cnt <= {CNT_W{1'b0}};
            r_wr_cnt     <= {CNT_W{1'b0}};
            r_push       <= 1'b0;
            r_entry      <= {TW{1'b0}};
        end else if (w_bubble) begin
            r_we    <= 1'b0;
            r_waddr <= REG_AW'(ZeroRegAddr);
            r_wdata <= XLEN'(ZeroWord);
            r_push  <= 1'b0;
        end else if (w_hold) begin
            // Outputs and counters hold; the staged push is a one-shot and must not repeat.
            r_push <= 1'b0;
        end else begin
            r_we    <= w_eff_we;
            r_waddr <= wd_i;
            r_wdata <= wdata_i;
            r_push  <= w_is_inst;
            if (w_is_inst) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                r_wr_cnt     <= r_wr_cnt + CNT_W'(w_eff_we);
                r_entry      <= {pc_i, inst_i, wd_i, wdata_i, w_eff_we};
            end
        end
    end

    wb_trace_fifo #(
        .W      (TW),
        .DEPTH  (TRACE_DEPTH),
        .DROP_W (DROP_W)
    ) u_trace_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push),
        .i_data  (r_entry),
        .i_ready (trace_ready),
        .o_valid (trace_valid),
        .o_data  (w_head),
        .o_drop  (trace_drop)
    );

    assign we          = r_we;
    assign waddr       = r_waddr;
    assign wdata       = r_wdata;
    assign retire_cnt  = r_retire_cnt;
    assign wr_cnt      = r_wr_cnt;
    assign trace_pc    = w_head[TW-1 -: XLEN];
    assign trace_inst  = w_head[TW-1-XLEN -: ILEN];
    assign trace_waddr = w_head[XLEN+1 +: REG_AW];
    assign trace_wdata = w_head[1 +: XLEN];
    assign trace_we    = w_head[0];

endmodule

// File: tb/tb_wb_commit_stage.sv
// Randomized, self-checking bench for wb_commit_stage against a queue-based reference model.
module tb_wb_commit_stage;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst, stall_i, stall_next_i, flush_i, wreg_i, trace_ready;
    logic [31:0] pc_i, inst_i, wdata_i;
    logic [4:0]  wd_i;
    logic        we, trace_valid, trace_we;
    logic [4:0]  waddr, trace_waddr;
    logic [31:0] wdata, trace_pc, trace_inst, trace_wdata;
    logic [63:0] retire_cnt, wr_cnt;
    logic [15:0] trace_drop;

    wb_commit_stage #(.TRACE_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .stall_next_i(stall_next_i), .flush_i(flush_i),
        .pc_i(pc_i), .inst_i(inst_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .we(we), .waddr(waddr), .wdata(wdata), .retire_cnt(retire_cnt), .wr_cnt(wr_cnt),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_inst(trace_inst), .trace_waddr(trace_waddr), .trace_wdata(trace_wdata),
        .trace_we(trace_we), .trace_drop(trace_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  a;
        logic [31:0] d;
        logic        w;
    } ent_t;

    // Reference model state
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [63:0] m_retire, m_wr;
    int          m_drop;
    ent_t        m_q[$];
    ent_t        m_pend;
    bit          m_pend_v;

    int checks = 0;
    int errors = 0;

    // Model the edge using the inputs currently driven, then advance past the edge.
    task automatic tick();
        bit eff;
        bit pop;
        pop = (m_q.size() > 0) && trace_ready;
        if (rst) begin
            m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
            m_retire = 64'd0; m_wr = 64'd0; m_drop = 0;
            m_q.delete(); m_pend_v = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_pend_v) begin
                if (m_q.size() < D) m_q.push_back(m_pend);
                else if (m_drop < 65535) m_drop = m_drop + 1;
            end
            m_pend_v = 1'b0;
            if (flush_i || (stall_i && !stall_next_i)) begin
                m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
            end else if (!stall_i) begin
                eff = wreg_i && (wd_i != 5'd0);
                m_we = eff; m_waddr = wd_i; m_wdata = wdata_i;
                if (inst_i != 32'd0) begin
                    m_retire = m_retire + 64'd1;
                    if (eff) m_wr = m_wr + 64'd1;
                    m_pend = '{pc_i, inst_i, wd_i, wdata_i, eff};
                    m_pend_v = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; stall_i = 1'b0; stall_next_i = 1'b0; flush_i = 1'b0;
        pc_i = 32'd0; inst_i = 32'd0; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] wd,
                         input logic wr, input logic [31:0] d);
        pc_i = pc; inst_i = inst; wd_i = wd; wreg_i = wr; wdata_i = d;
    endtask

    task automatic test_reset();
        idle(); trace_ready = 1'b0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %0d want 0", we); end
        checks++; if (retire_cnt !== 64'd0) begin errors++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", trace_valid); end
        checks++; if (trace_drop !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", trace_drop); end
        checks++; if (trace_pc !== 32'd0) begin errors++; $display("FAIL reset_tpc got %h want 0", trace_pc); end
    endtask

    task automatic test_commit();
        drive(32'h100, 32'h00500093, 5'd1, 1'b1, 32'd5); tick(); idle();
        checks++; if ({we, waddr, wdata} !== {1'b1, 5'd1, 32'd5}) begin errors++; $display("FAIL commit_port got %0d/%0d/%0d want 1/1/5", we, waddr, wdata); end
        checks++; if (retire_cnt !== 64'd1 || wr_cnt !== 64'd1) begin errors++; $display("FAIL commit_cnt got %0d/%0d want 1/1", retire_cnt, wr_cnt); end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL commit_early_valid got %0d want 0", trace_valid); end
        tick();
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h100) begin errors++; $display("FAIL commit_trace got %0d/%h want 1/100", trace_valid, trace_pc); end
    endtask

    task automatic test_x0_store();
        drive(32'h104, 32'h00000013, 5'd0, 1'b1, 32'd9); tick();
        checks++; if (we !== 1'b0 || retire_cnt !== 64'd2 || wr_cnt !== 64'd1) begin errors++; $display("FAIL x0 got we=%0d r=%0d w=%0d want 0/2/1", we, retire_cnt, wr_cnt); end
        drive(32'h108, 32'h00112023, 5'd4, 1'b0, 32'd7); tick(); idle();
        checks++; if (we !== 1'b0 || retire_cnt !== 64'd3 || wr_cnt !== 64'd1) begin errors++; $display("FAIL store got we=%0d r=%0d w=%0d want 0/3/1", we, retire_cnt, wr_cnt); end
    endtask

    task automatic test_stall();
        drive(32'h10c, 32'h0aa00193, 5'd3, 1'b1, 32'hAA); tick();
        drive(32'h200, 32'h00100213, 5'd4, 1'b1, 32'h55);
        stall_i = 1'b1; stall_next_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'hAA} || retire_cnt !== 64'd4) begin errors++; $display("FAIL hold got %0d/%0d/%h r=%0d want 1/3/aa r=4", we, waddr, wdata, retire_cnt); end
        end
        stall_next_i = 1'b0; tick();
        checks++; if (we !== 1'b0 || waddr !== 5'd0 || retire_cnt !== 64'd4) begin errors++; $display("FAIL stall_bubble got %0d/%0d r=%0d want 0/0 r=4", we, waddr, retire_cnt); end
        stall_i = 1'b0; flush_i = 1'b1; tick(); flush_i = 1'b0; idle(); tick();
        checks++; if (we !== 1'b0 || retire_cnt !== 64'd4 || wr_cnt !== 64'd2) begin errors++; $display("FAIL flush got %0d r=%0d w=%0d want 0/4/2", we, retire_cnt, wr_cnt); end
        checks++; if (trace_drop !== 16'd0 || trace_pc !== 32'h100) begin errors++; $display("FAIL flush_trace got d=%0d pc=%h want 0/100", trace_drop, trace_pc); end
    endtask

    task automatic test_fifo();
        rst = 1'b1; tick(); idle(); trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(32'h1000 + 32'(i * 4), 32'h13 + 32'(i << 7), 5'(i + 1), 1'b1, 32'(i)); tick();
        end
        idle(); tick();
        checks++; if (trace_drop !== 16'd2 || trace_valid !== 1'b1) begin errors++; $display("FAIL fifo_drop got d=%0d v=%0d want 2/1", trace_drop, trace_valid); end
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h1000 + 32'(i * 4) || trace_waddr !== 5'(i + 1)) begin errors++; $display("FAIL drain%0d got v=%0d pc=%h a=%0d want pc=%h", i, trace_valid, trace_pc, trace_waddr, 32'h1000 + 32'(i * 4)); end
            tick();
        end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0d want 0", trace_valid); end
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(32'h2000 + 32'(i * 4), 32'h33, 5'd2, 1'b1, 32'd1); tick();
        end
        idle(); tick(); trace_ready = 1'b1;
        drive(32'h3000, 32'h33, 5'd2, 1'b1, 32'd1); tick(); idle(); tick();
        checks++; if (trace_drop !== 16'd2 || trace_pc !== 32'h2008) begin errors++; $display("FAIL full_pop got d=%0d pc=%h want 2/2008", trace_drop, trace_pc); end
        trace_ready = 1'b0;
    endtask

    task automatic test_bubble_reset();
        drive(32'h400, 32'h0, 5'd7, 1'b1, 32'h77); tick();
        checks++; if (we !== 1'b1 || waddr !== 5'd7 || retire_cnt !== m_retire) begin errors++; $display("FAIL bubble got we=%0d a=%0d r=%0d want 1/7/%0d", we, waddr, retire_cnt, m_retire); end
        rst = 1'b1; tick(); idle();
        for (int i = 0; i < 4; i++) begin
            drive(32'h500 + 32'(i), 32'h93, 5'd1, 1'b1, 32'd3); tick();
        end
        idle(); tick();
        checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL half_full got %0d want 1", trace_valid); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (trace_valid !== 1'b0 || retire_cnt !== 64'd0 || wr_cnt !== 64'd0 || trace_drop !== 16'd0) begin errors++; $display("FAIL mid_reset got v=%0d r=%0d w=%0d d=%0d want 0/0/0/0", trace_valid, retire_cnt, wr_cnt, trace_drop); end
    endtask

    task automatic test_random();
        ent_t h;
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 79) == 0);
            stall_i      = ($urandom_range(0, 3) == 0);
            stall_next_i = $urandom_range(0, 1) == 1;
            flush_i      = ($urandom_range(0, 9) == 0);
            trace_ready  = ($urandom_range(0, 2) == 0);
            drive($urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom | 32'd1),
                  5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1, $urandom);
            tick();
            h = '{32'd0, 32'd0, 5'd0, 32'd0, 1'b0};
            if (m_q.size() > 0) h = m_q[0];
            checks++; if ({we, waddr, wdata} !== {m_we, m_waddr, m_wdata}) begin errors++; $display("FAIL rnd_port@%0d got %0d/%0d/%h want %0d/%0d/%h", n, we, waddr, wdata, m_we, m_waddr, m_wdata); end
            checks++; if (retire_cnt !== m_retire || wr_cnt !== m_wr) begin errors++; $display("FAIL rnd_cnt@%0d got %0d/%0d want %0d/%0d", n, retire_cnt, wr_cnt, m_retire, m_wr); end
            checks++; if (trace_valid !== (m_q.size() > 0) || trace_drop !== 16'(m_drop)) begin errors++; $display("FAIL rnd_fifo@%0d got v=%0d d=%0d want v=%0d d=%0d", n, trace_valid, trace_drop, m_q.size() > 0, m_drop); end
            checks++; if ({trace_pc, trace_inst, trace_waddr, trace_wdata, trace_we} !== {h.pc, h.inst, h.a, h.d, h.w}) begin errors++; $display("FAIL rnd_head@%0d got pc=%h i=%h a=%0d d=%h w=%0d want pc=%h i=%h a=%0d d=%h w=%0d", n, trace_pc, trace_inst, trace_waddr, trace_wdata, trace_we, h.pc, h.inst, h.a, h.d, h.w); end
        end
    endtask

    initial begin
        idle(); trace_ready = 1'b0;
        m_pend_v = 1'b0; m_drop = 0; m_retire = 64'd0; m_wr = 64'd0;
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        test_reset();
        test_commit();
        test_x0_store();
        test_stall();
        test_fifo();
        test_bubble_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
